// File: rtl/ysyx_24100006_wb_pkg.sv
// Shared write-back definitions: WBU state encoding, GPR source selects and
// load-type (funct3) encodings also consumed by the LSU.
package ysyx_24100006_wb_pkg;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_COMMIT = 2'd1,
    WB_TRAP   = 2'd2,
    WB_FLUSH  = 2'd3
  } wb_state_t;

  localparam logic [1:0] GPR_SEL_DEC = 2'b00;
  localparam logic [1:0] GPR_SEL_ALU = 2'b01;
  localparam logic [1:0] GPR_SEL_MEM = 2'b10;

  localparam logic [2:0] MASK_LB  = 3'b000;
  localparam logic [2:0] MASK_LH  = 3'b001;
  localparam logic [2:0] MASK_LW  = 3'b010;
  localparam logic [2:0] MASK_LBU = 3'b100;
  localparam logic [2:0] MASK_LHU = 3'b101;

endpackage

// File: rtl/ysyx_24100006_load_ext.sv
// Combinational load extension: picks the byte/half at the byte offset and
// sign- or zero-extends it; unknown load types pass the full word through.
module ysyx_24100006_load_ext
  import ysyx_24100006_wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      mask,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    // Halfword offset ignores bit 0; misaligned halves are not split.
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (mask)
      MASK_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      MASK_LH:  data = {{(XLEN-16){half_sel[15]}}, half_sel};
      MASK_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      MASK_LHU: data = {{(XLEN-16){1'b0}}, half_sel};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_24100006_wbu.sv
// Write-back stage: registered GPR/CSR write strobes, load extension and the
// trap -> flush/redirect sequence. WBU_DIFFTEST_EN adds retirement tracing ports.
module ysyx_24100006_wbu
  import ysyx_24100006_wb_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned GPR_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_out_valid,
  output logic              wb_out_ready,
  input  logic              Gpr_Write_M,
  input  logic [GPR_AW-1:0] Gpr_Write_Addr_M,
  input  logic [1:0]        Gpr_Write_RD_M,
  input  logic [XLEN-1:0]   alu_result_M,
  input  logic [XLEN-1:0]   wdata_gpr_M,
  input  logic [XLEN-1:0]   mem_rdata_M,
  input  logic [1:0]        mem_addr_lo_M,
  input  logic [2:0]        Mem_Mask_M,
  input  logic              Csr_Write_M,
  input  logic [11:0]       Csr_Write_Addr_M,
  input  logic [XLEN-1:0]   wdata_csr_M,
  input  logic              irq_M,
  input  logic [3:0]        irq_no_M,
  input  logic [XLEN-1:0]   mtvec_i,
  output logic              Gpr_Write_W,
  output logic [GPR_AW-1:0] Gpr_Write_Addr_W,
  output logic [XLEN-1:0]   wdata_gpr_W,
  output logic              Csr_Write_W,
  output logic [11:0]       Csr_Write_Addr_W,
  output logic [XLEN-1:0]   wdata_csr_W,
  output logic              irq_W,
  output logic [3:0]        irq_no_W,
  output logic              flush_o,
  output logic [XLEN-1:0]   redirect_pc_o,
`ifdef WBU_DIFFTEST_EN
  input  logic [XLEN-1:0]   pc_M,
  input  logic              is_break_M,
  output logic              retire_o,
  output logic [XLEN-1:0]   pc_W,
  output logic              ebreak_W,
  output logic [31:0]       retire_cnt,
`endif
  output logic [XLEN-1:0]   wb_fw_data
);

  wb_state_t       state;
  logic            accept;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] gpr_data;

  assign wb_out_ready = (state == WB_IDLE) || (state == WB_COMMIT);
  assign accept       = wb_out_valid & wb_out_ready;
  assign wb_fw_data   = wdata_gpr_W;
  // mtvec is sampled live in the FLUSH cycle so the TRAP-cycle CSR update is seen.
  assign redirect_pc_o = flush_o ? mtvec_i : '0;

  ysyx_24100006_load_ext #(.XLEN(XLEN)) u_load_ext (
    .rdata   (mem_rdata_M),
    .addr_lo (mem_addr_lo_M),
    .mask    (Mem_Mask_M),
    .data    (load_data)
  );

  always_comb begin
    case (Gpr_Write_RD_M)
      GPR_SEL_ALU: gpr_data = alu_result_M;
      GPR_SEL_MEM: gpr_data = load_data;
      default:     gpr_data = wdata_gpr_M;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= WB_IDLE;
      Gpr_Write_W      <= 1'b0;
      Gpr_Write_Addr_W <= '0;
      wdata_gpr_W      <= '0;
      Csr_Write_W      <= 1'b0;
      Csr_Write_Addr_W <= '0;
      wdata_csr_W      <= '0;
      irq_W            <= 1'b0;
      irq_no_W         <= '0;
      flush_o          <= 1'b0;
    end else begin
      Gpr_Write_W <= 1'b0;
      Csr_Write_W <= 1'b0;
      irq_W       <= 1'b0;
      flush_o     <= 1'b0;
      case (state)
        WB_IDLE, WB_COMMIT: begin
          if (accept) begin
            Gpr_Write_W      <= Gpr_Write_M & (Gpr_Write_Addr_M != '0) & ~irq_M;
            Gpr_Write_Addr_W <= Gpr_Write_Addr_M;
            wdata_gpr_W      <= gpr_data;
            Csr_Write_W      <= Csr_Write_M & ~irq_M;
            Csr_Write_Addr_W <= Csr_Write_Addr_M;
            wdata_csr_W      <= wdata_csr_M;
            irq_W            <= irq_M;
            irq_no_W         <= irq_no_M;
            state            <= irq_M ? WB_TRAP : WB_COMMIT;
          end else begin
            state <= WB_IDLE;
          end
        end
        WB_TRAP: begin
          flush_o <= 1'b1;
          state   <= WB_FLUSH;
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

`ifdef WBU_DIFFTEST_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      retire_o   <= 1'b0;
      pc_W       <= '0;
      ebreak_W   <= 1'b0;
      retire_cnt <= '0;
    end else begin
      retire_o <= accept;
      if (accept) begin
        pc_W       <= pc_M;
        ebreak_W   <= is_break_M;
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_24100006_wbu.sv
// Bench for the write-back stage: directed vector table, trap/reset sequences
// and a randomized run against a cycle-level reference model.
module tb_ysyx_24100006_wbu;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_out_valid, wb_out_ready;
  logic        Gpr_Write_M;
  logic [3:0]  Gpr_Write_Addr_M;
  logic [1:0]  Gpr_Write_RD_M;
  logic [31:0] alu_result_M, wdata_gpr_M, mem_rdata_M;
  logic [1:0]  mem_addr_lo_M;
  logic [2:0]  Mem_Mask_M;
  logic        Csr_Write_M;
  logic [11:0] Csr_Write_Addr_M;
  logic [31:0] wdata_csr_M;
  logic        irq_M;
  logic [3:0]  irq_no_M;
  logic [31:0] mtvec_i;
  logic        Gpr_Write_W;
  logic [3:0]  Gpr_Write_Addr_W;
  logic [31:0] wdata_gpr_W;
  logic        Csr_Write_W;
  logic [11:0] Csr_Write_Addr_W;
  logic [31:0] wdata_csr_W;
  logic        irq_W;
  logic [3:0]  irq_no_W;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] wb_fw_data;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ysyx_24100006_wbu #(.XLEN(32), .GPR_AW(4)) dut (
    .clk(clk), .reset(reset),
    .wb_out_valid(wb_out_valid), .wb_out_ready(wb_out_ready),
    .Gpr_Write_M(Gpr_Write_M), .Gpr_Write_Addr_M(Gpr_Write_Addr_M), .Gpr_Write_RD_M(Gpr_Write_RD_M),
    .alu_result_M(alu_result_M), .wdata_gpr_M(wdata_gpr_M),
    .mem_rdata_M(mem_rdata_M), .mem_addr_lo_M(mem_addr_lo_M), .Mem_Mask_M(Mem_Mask_M),
    .Csr_Write_M(Csr_Write_M), .Csr_Write_Addr_M(Csr_Write_Addr_M), .wdata_csr_M(wdata_csr_M),
    .irq_M(irq_M), .irq_no_M(irq_no_M), .mtvec_i(mtvec_i),
    .Gpr_Write_W(Gpr_Write_W), .Gpr_Write_Addr_W(Gpr_Write_Addr_W), .wdata_gpr_W(wdata_gpr_W),
    .Csr_Write_W(Csr_Write_W), .Csr_Write_Addr_W(Csr_Write_Addr_W), .wdata_csr_W(wdata_csr_W),
    .irq_W(irq_W), .irq_no_W(irq_no_W), .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
    .wb_fw_data(wb_fw_data)
  );

  typedef struct {
    logic        gw;
    logic [3:0]  addr;
    logic [1:0]  rd;
    logic [31:0] alu;
    logic [31:0] wgpr;
    logic [31:0] rdata;
    logic [1:0]  off;
    logic [2:0]  mask;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wb_out_valid = 0; Gpr_Write_M = 0; Gpr_Write_Addr_M = 0; Gpr_Write_RD_M = 0;
    alu_result_M = 0; wdata_gpr_M = 0; mem_rdata_M = 0; mem_addr_lo_M = 0; Mem_Mask_M = 0;
    Csr_Write_M = 0; Csr_Write_Addr_M = 0; wdata_csr_M = 0; irq_M = 0; irq_no_M = 0;
  endtask

  // Reference load extension from the ISA's LB/LH/LW/LBU/LHU definitions.
  function automatic logic [31:0] load_model(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] m);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (m)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_gpr_we"},   {31'd0, Gpr_Write_W}, 0);
    chk({tag, "_gpr_addr"}, {28'd0, Gpr_Write_Addr_W}, 0);
    chk({tag, "_gpr_data"}, wdata_gpr_W, 0);
    chk({tag, "_csr_we"},   {31'd0, Csr_Write_W}, 0);
    chk({tag, "_csr_addr"}, {20'd0, Csr_Write_Addr_W}, 0);
    chk({tag, "_csr_data"}, wdata_csr_W, 0);
    chk({tag, "_irq"},      {31'd0, irq_W}, 0);
    chk({tag, "_irq_no"},   {28'd0, irq_no_W}, 0);
    chk({tag, "_flush"},    {31'd0, flush_o}, 0);
    chk({tag, "_fw"},       wb_fw_data, 0);
  endtask

  initial begin
    int          ph;
    logic        acc, v, gw, cw, irq;
    logic [3:0]  ga, ino, exp_ino;
    logic [1:0]  rd, off;
    logic [2:0]  mk;
    logic [11:0] ca;
    logic [31:0] alu, wg, rdw, cd;
    logic        e_gwe, e_cwe;
    logic [3:0]  e_ga;
    logic [31:0] e_gd, e_cd;
    logic [11:0] e_ca;

    tbl[0] = '{1, 4'd5,  2'b10, 32'h0,    32'h0,        32'h80FF7F01, 2'd3, 3'b000, 1, 32'hFFFFFF80};
    tbl[1] = '{1, 4'd6,  2'b10, 32'h0,    32'h0,        32'h80FF7F01, 2'd2, 3'b101, 1, 32'h000080FF};
    tbl[2] = '{1, 4'd7,  2'b10, 32'h0,    32'h0,        32'h80FF7F01, 2'd0, 3'b001, 1, 32'h00007F01};
    tbl[3] = '{1, 4'd0,  2'b01, 32'hDEAD, 32'h0,        32'h0,        2'd0, 3'b010, 0, 32'h0000DEAD};
    tbl[4] = '{1, 4'd3,  2'b01, 32'h1234, 32'h0,        32'h0,        2'd0, 3'b010, 1, 32'h00001234};
    tbl[5] = '{1, 4'd9,  2'b11, 32'h1111, 32'hCAFEF00D, 32'h0,        2'd0, 3'b010, 1, 32'hCAFEF00D};
    tbl[6] = '{1, 4'd10, 2'b10, 32'h0,    32'h0,        32'h80FF7F01, 2'd1, 3'b000, 1, 32'h0000007F};
    tbl[7] = '{0, 4'd11, 2'b10, 32'h0,    32'h0,        32'h80FF7F01, 2'd1, 3'b111, 0, 32'h80FF7F01};

    clear_inputs();
    mtvec_i = 32'h80000100;
    reset = 0;
    step(); step();
    check_all_zero("reset");
    reset = 1;
    chk("reset_ready", {31'd0, wb_out_ready}, 1);

    // Back-to-back table beats; ready must stay high throughout.
    for (int i = 0; i < 8; i++) begin
      wb_out_valid = 1; Gpr_Write_M = tbl[i].gw; Gpr_Write_Addr_M = tbl[i].addr;
      Gpr_Write_RD_M = tbl[i].rd; alu_result_M = tbl[i].alu; wdata_gpr_M = tbl[i].wgpr;
      mem_rdata_M = tbl[i].rdata; mem_addr_lo_M = tbl[i].off; Mem_Mask_M = tbl[i].mask;
      chk("tbl_ready", {31'd0, wb_out_ready}, 1);
      step();
      chk("tbl_we",   {31'd0, Gpr_Write_W}, {31'd0, tbl[i].exp_we});
      chk("tbl_addr", {28'd0, Gpr_Write_Addr_W}, {28'd0, tbl[i].addr});
      chk("tbl_data", wdata_gpr_W, tbl[i].exp_data);
      chk("tbl_fw",   wb_fw_data, tbl[i].exp_data);
    end
    clear_inputs();
    step();
    chk("idle_we", {31'd0, Gpr_Write_W}, 0);

    // csrrw mtvec: one-cycle CSR strobe.
    wb_out_valid = 1; Csr_Write_M = 1; Csr_Write_Addr_M = 12'h305; wdata_csr_M = 32'h80000200;
    step();
    clear_inputs();
    chk("csr_we",   {31'd0, Csr_Write_W}, 1);
    chk("csr_addr", {20'd0, Csr_Write_Addr_W}, 32'h305);
    chk("csr_data", wdata_csr_W, 32'h80000200);
    step();
    chk("csr_we_drop", {31'd0, Csr_Write_W}, 0);

    // Ecall; upstream keeps a GPR-writing beat pending through the trap.
    wb_out_valid = 1; irq_M = 1; irq_no_M = 4'd11; Gpr_Write_M = 1; Gpr_Write_Addr_M = 4'd4;
    Csr_Write_M = 1; Csr_Write_Addr_M = 12'h300;
    step();
    irq_M = 0; irq_no_M = 0;
    chk("trap_irq",    {31'd0, irq_W}, 1);
    chk("trap_irq_no", {28'd0, irq_no_W}, 11);
    chk("trap_gpr_we", {31'd0, Gpr_Write_W}, 0);
    chk("trap_csr_we", {31'd0, Csr_Write_W}, 0);
    chk("trap_ready",  {31'd0, wb_out_ready}, 0);
    chk("trap_flush",  {31'd0, flush_o}, 0);
    step();
    chk("flush_flush",    {31'd0, flush_o}, 1);
    chk("flush_redirect", redirect_pc_o, 32'h80000100);
    chk("flush_irq",      {31'd0, irq_W}, 0);
    chk("flush_ready",    {31'd0, wb_out_ready}, 0);
    chk("flush_gpr_we",   {31'd0, Gpr_Write_W}, 0);
    step();
    chk("post_flush",   {31'd0, flush_o}, 0);
    chk("post_ready",   {31'd0, wb_out_ready}, 1);
    chk("post_gpr_we",  {31'd0, Gpr_Write_W}, 0);
    clear_inputs();
    step();

    // Reset landing in the TRAP cycle aborts the flush.
    wb_out_valid = 1; irq_M = 1; irq_no_M = 4'd3;
    step();
    clear_inputs();
    chk("rtrap_irq", {31'd0, irq_W}, 1);
    reset = 0;
    step();
    check_all_zero("rtrap");
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      chk("rtrap_ready", {31'd0, wb_out_ready}, 1);
      step();
      chk("rtrap_noflush", {31'd0, flush_o}, 0);
      chk("rtrap_noirq",   {31'd0, irq_W}, 0);
    end

    // Randomized run: ph counts the remaining non-accepting trap cycles (2 = TRAP, 1 = FLUSH).
    ph = 0; e_ga = 0; e_gd = 0; e_ca = 0; e_cd = 0; exp_ino = 0;
    for (int c = 0; c < 600; c++) begin
      v = ($urandom_range(0, 3) != 0); gw = $urandom_range(0, 1) == 1; ga = 4'($urandom);
      rd = 2'($urandom); alu = $urandom; wg = $urandom; rdw = $urandom; off = 2'($urandom);
      mk = 3'($urandom); cw = $urandom_range(0, 1) == 1; ca = 12'($urandom); cd = $urandom;
      irq = ($urandom_range(0, 9) == 0); ino = 4'($urandom);
      wb_out_valid = v; Gpr_Write_M = gw; Gpr_Write_Addr_M = ga; Gpr_Write_RD_M = rd;
      alu_result_M = alu; wdata_gpr_M = wg; mem_rdata_M = rdw; mem_addr_lo_M = off;
      Mem_Mask_M = mk; Csr_Write_M = cw; Csr_Write_Addr_M = ca; wdata_csr_M = cd;
      irq_M = irq; irq_no_M = ino; mtvec_i = $urandom;
      chk("rnd_ready", {31'd0, wb_out_ready}, {31'd0, ph == 0});
      acc = v && (ph == 0);
      step();
      if (ph > 0) ph--;
      else if (acc && irq) ph = 2;
      e_gwe = 0; e_cwe = 0;
      if (acc) begin
        e_gwe = gw && (ga != 0) && !irq;
        e_cwe = cw && !irq;
        e_ga = ga; e_ca = ca; e_cd = cd; exp_ino = ino;
        e_gd = (rd == 2'b01) ? alu : (rd == 2'b10) ? load_model(rdw, off, mk) : wg;
      end
      chk("rnd_gpr_we",   {31'd0, Gpr_Write_W}, {31'd0, e_gwe});
      chk("rnd_gpr_addr", {28'd0, Gpr_Write_Addr_W}, {28'd0, e_ga});
      chk("rnd_gpr_data", wdata_gpr_W, e_gd);
      chk("rnd_fw",       wb_fw_data, e_gd);
      chk("rnd_csr_we",   {31'd0, Csr_Write_W}, {31'd0, e_cwe});
      chk("rnd_csr_addr", {20'd0, Csr_Write_Addr_W}, {20'd0, e_ca});
      chk("rnd_csr_data", wdata_csr_W, e_cd);
      chk("rnd_irq",      {31'd0, irq_W}, {31'd0, ph == 2});
      chk("rnd_flush",    {31'd0, flush_o}, {31'd0, ph == 1});
      if (ph == 2) chk("rnd_irq_no", {28'd0, irq_no_W}, {28'd0, exp_ino});
      if (ph == 1) chk("rnd_redirect", redirect_pc_o, mtvec_i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_wbu.md
# ysyx_24100006_wbu

Write-back stage of the pipelined RV32E core. It accepts retiring instructions from the MEM/WB boundary over a valid/ready handshake, performs load-data extension, and selects the GPR write value. It drives the registered one-cycle GPR/CSR write and trap strobes that the decode stage's register files consume. On a trap it sequences the CSR trap update and then a pipeline flush with redirect to `mtvec`.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `GPR_AW`, 4, GPR address width (RV32E, 16 registers).

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-low reset.
- `wb_out_valid`  in  1  MEM/WB → WBU upstream valid.
- `wb_out_ready`  out  1  WBU → MEM/WB upstream ready.
- `Gpr_Write_M`, `Gpr_Write_Addr_M[3:0]`, `Gpr_Write_RD_M[1:0]`  in  GPR write enable, address and source select.
- `alu_result_M[31:0]`, `wdata_gpr_M[31:0]`  in  ALU result; decode-formed value (imm, pc+4 or CSR read).
- `mem_rdata_M[31:0]`, `mem_addr_lo_M[1:0]`, `Mem_Mask_M[2:0]`  in  raw load word, byte offset, load type.
- `Csr_Write_M`, `Csr_Write_Addr_M[11:0]`, `wdata_csr_M[31:0]`  in  CSR write request.
- `irq_M`, `irq_no_M[3:0]`  in  trap request and cause.
- `mtvec_i[31:0]`  in  current mtvec from the CSR file.
- `Gpr_Write_W`, `Gpr_Write_Addr_W[3:0]`, `wdata_gpr_W[31:0]`  out  GPR write strobe, address, data.
- `Csr_Write_W`, `Csr_Write_Addr_W[11:0]`, `wdata_csr_W[31:0]`  out  CSR write strobe, address, data.
- `irq_W`, `irq_no_W[3:0]`  out  trap strobe to the CSR file (mepc/mcause update).
- `flush_o`  out  1  flush IF/ID/EXE/MEM.
- `redirect_pc_o[31:0]`  out  new fetch PC, valid with `flush_o`.
- `wb_fw_data[31:0]`  out  equals `wdata_gpr_W`; feeds the hazard/forward unit.

## Operation
- Accept occurs when `wb_out_valid & wb_out_ready` at a rising edge.
- `wb_out_ready` = 1 in IDLE and COMMIT, 0 in TRAP and FLUSH.
- States:
  - IDLE: no accepted beat.
  - COMMIT: outputs hold the last accepted beat for one cycle.
  - TRAP: `irq_W` pulse.
  - FLUSH: `flush_o` pulse.
- State transitions:
  - Accept with `irq_M`=1 → TRAP.
  - Accept with `irq_M`=0 → COMMIT.
  - No accept from IDLE/COMMIT → IDLE.
  - TRAP → FLUSH.
  - FLUSH → IDLE.
- GPR data select by `Gpr_Write_RD_M`:
  - 00: `wdata_gpr_M`.
  - 01: `alu_result_M`.
  - 10: extended load data.
  - 11: treated as 00.
- Load extension (`Mem_Mask_M`, funct3 encoding), byte/half taken at `mem_addr_lo_M`:
  - 000: LB, sign-extend byte.
  - 001: LH, sign-extend half; half offset is bit 1 only.
  - 010: LW, full word.
  - 100: LBU, zero-extend byte.
  - 101: LHU, zero-extend half.
  - Other values: full word.
- `Gpr_Write_W` = `Gpr_Write_M` & (addr ≠ 0) & ~`irq_M`. Writes to x0 are suppressed; data is still registered.
- `Csr_Write_W` = `Csr_Write_M` & ~`irq_M`. A trapping instruction never writes GPR or CSR.
- TRAP cycle: `irq_W`=1 and `irq_no_W` = latched cause.
- FLUSH cycle: `flush_o`=1 and `redirect_pc_o` = `mtvec_i` sampled in that cycle, so the TRAP-cycle CSR update is visible.

## Timing
- All outputs are registered. Write strobes assert in the cycle after accept and last exactly one cycle unless another beat is accepted.
- Back-to-back accepts in COMMIT give one retirement per cycle, with no bubble.
- Trap costs 2 non-accepting cycles: accept → TRAP → FLUSH → IDLE (ready returns in the IDLE cycle).
- Reset (`reset`=0 at an edge):
  - state ← IDLE.
  - All strobes, `flush_o`, `irq_W`, `irq_no_W`, addresses and data ← 0.
  - `wb_out_ready` = 1 from the first cycle after reset.
- Reset during TRAP or FLUSH aborts the sequence; no further `irq_W`/`flush_o` is emitted.
- `wb_out_valid` high while ready=0 is held by upstream; WBU does not sample it.

## Configuration
- `WBU_DIFFTEST_EN` defined adds outputs:
  - `retire_o` (1-cycle pulse per committed or trapped instruction, in COMMIT/TRAP).
  - `pc_W[31:0]`, latched from input `pc_M`.
  - `ebreak_W`, latched from input `is_break_M`.
  - `retire_cnt[31:0]`, a wrapping counter, 0 at reset.
- Not defined: those ports, inputs `pc_M`/`is_break_M`, and all associated registers are absent; the functional behaviour is otherwise identical.

## Structure
- Shared package `ysyx_24100006_wb_pkg`:
  - WBU state encoding (IDLE/COMMIT/TRAP/FLUSH).
  - `Gpr_Write_RD` select constants.
  - `Mem_Mask` load-type constants, also used by the LSU.
- Sub-module `ysyx_24100006_load_ext`: combinational load extension (raw word, offset, mask → 32-bit).

## Test plan
- LB, `mem_rdata_M`=0x80FF7F01, offset 3, RD=10, addr 5 → next cycle `Gpr_Write_W`=1, addr 5, data 0xFFFFFF80.
- LHU with the same word, offset 2 → data 0x000080FF. LH with the same word, offset 0 → 0x00007F01.
- Back-to-back ALU writes to addr 0 then addr 3 (0x1234) → `Gpr_Write_W` 0 then 1; `wb_out_ready` stays 1 throughout.
- Ecall beat: `irq_M`=1, `irq_no_M`=11, `Gpr_Write_M`=1, `mtvec_i`=0x80000100 → TRAP cycle `irq_W`=1, `irq_no_W`=11, `Gpr_Write_W`=0; FLUSH cycle `flush_o`=1, `redirect_pc_o`=0x80000100; ready=0 for both cycles.
- csrrw to 0x305 with `wdata_csr_M`=0x80000200 → one-cycle `Csr_Write_W`=1, addr 0x305, data 0x80000200.
- Assert reset in the TRAP cycle → no `flush_o` pulse; all outputs 0; ready=1 after release.
